// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute hazard inputs plus stage enables, flushes and counters.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ex_mem_read;
   logic [4:0]       ex_rd;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_md_start;
   logic             id_md_use;
   logic             mem_redirect;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ex_mem_read, ex_rd, id_rs, id_rt, id_use_rs, id_use_rt,
             id_md_start, id_md_use, mem_redirect,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, md_busy, stall_cnt, flush_cnt
   );

   modport slave (
      input  ex_mem_read, ex_rd, id_rs, id_rt, id_use_rs, id_use_rt,
             id_md_start, id_md_use, mem_redirect,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, md_busy, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: redirect > MD-unit hazard > load-use.
// Enables/flushes are combinational; MD occupancy and saturating perf counters are registered.
module pipe_hazard_ctrl #(
   parameter int MD_CYCLES = 5,
   parameter int CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   pipe_hazard_ctrl_if.slave hz
);

   logic [4:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic lu_haz, md_haz, redir, stall;

   always_comb begin
      lu_haz = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));
      md_haz = (md_cnt_q != 5'd0) && (hz.id_md_use || hz.id_md_start);
      redir  = hz.mem_redirect;
      stall  = (lu_haz || md_haz) && !redir;
   end

   // Everything is held low while reset is asserted, so the stage registers freeze.
   always_comb begin
      hz.pc_en        = 1'b0;
      hz.if_id_en     = 1'b0;
      hz.id_ex_en     = 1'b0;
      hz.ex_mem_en    = 1'b0;
      hz.mem_wb_en    = 1'b0;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_flush  = 1'b0;
      hz.ex_mem_flush = 1'b0;
      if (rst_n_i) begin
         hz.id_ex_en  = 1'b1;
         hz.ex_mem_en = 1'b1;
         hz.mem_wb_en = 1'b1;
         if (redir) begin
            hz.pc_en        = 1'b1;
            hz.if_id_en     = 1'b1;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.ex_mem_flush = 1'b1;
         end else if (stall) begin
            hz.id_ex_flush = 1'b1;
         end else begin
            hz.pc_en    = 1'b1;
            hz.if_id_en = 1'b1;
         end
      end
   end

   // A redirect does not stop a running count: the op issued before the flush.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (hz.id_md_start && !stall && !redir) begin
         md_cnt_d = 5'(MD_CYCLES);
      end else if (md_cnt_q != 5'd0) begin
         md_cnt_d = md_cnt_q - 5'd1;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      flush_cnt_d = flush_cnt_q;
      if (redir && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         md_cnt_q    <= 5'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.md_busy   = (md_cnt_q != 5'd0);
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded bench for pipe_hazard_ctrl; a second 4-bit-counter instance shadows the stimulus.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       mds;
      logic       mdu;
      logic       redir;
   } stim_t;

   typedef struct packed {
      logic [7:0]  ctl;   // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush}
      logic        busy;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   localparam logic [7:0] C_NORM  = 8'b11111_000;
   localparam logic [7:0] C_STALL = 8'b00111_010;
   localparam logic [7:0] C_REDIR = 8'b11111_111;
   localparam logic [7:0] C_OFF   = 8'b00000_000;

   localparam stim_t S_IDLE = '0;
   localparam stim_t S_LU  = '{mr:1'b1, rd:5'd8, rs:5'd8, rt:5'd0, urs:1'b1, urt:1'b0,
                               mds:1'b0, mdu:1'b0, redir:1'b0};
   localparam stim_t S_MDS = '{mr:1'b0, rd:5'd0, rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0,
                               mds:1'b1, mdu:1'b0, redir:1'b0};
   localparam stim_t S_MDU = '{mr:1'b0, rd:5'd0, rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0,
                               mds:1'b0, mdu:1'b1, redir:1'b0};
   localparam stim_t S_RED = '{mr:1'b0, rd:5'd0, rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0,
                               mds:1'b0, mdu:1'b0, redir:1'b1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(16)) if1 ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  if2 ();

   pipe_hazard_ctrl #(.MD_CYCLES(5), .CNT_W(16)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .hz      (if1.slave)
   );

   pipe_hazard_ctrl #(.MD_CYCLES(5), .CNT_W(4)) dut_sat (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .hz      (if2.slave)
   );

   assign if2.ex_mem_read  = if1.ex_mem_read;
   assign if2.ex_rd        = if1.ex_rd;
   assign if2.id_rs        = if1.id_rs;
   assign if2.id_rt        = if1.id_rt;
   assign if2.id_use_rs    = if1.id_use_rs;
   assign if2.id_use_rt    = if1.id_use_rt;
   assign if2.id_md_start  = if1.id_md_start;
   assign if2.id_md_use    = if1.id_md_use;
   assign if2.mem_redirect = if1.mem_redirect;

   logic [7:0] ctl1;
   exp_t       obs1;
   assign ctl1 = {if1.pc_en, if1.if_id_en, if1.id_ex_en, if1.ex_mem_en, if1.mem_wb_en,
                  if1.if_id_flush, if1.id_ex_flush, if1.ex_mem_flush};
   assign obs1 = {ctl1, if1.md_busy, if1.stall_cnt, if1.flush_cnt};

   exp_t sb[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic exp_t mk(logic [7:0] ctl, logic busy, int sc, int fc);
      mk = '{ctl:ctl, busy:busy, sc:16'(sc), fc:16'(fc)};
   endfunction

   task automatic apply(input stim_t s);
      if1.ex_mem_read  = s.mr;
      if1.ex_rd        = s.rd;
      if1.id_rs        = s.rs;
      if1.id_rt        = s.rt;
      if1.id_use_rs    = s.urs;
      if1.id_use_rt    = s.urt;
      if1.id_md_start  = s.mds;
      if1.id_md_use    = s.mdu;
      if1.mem_redirect = s.redir;
   endtask

   // Drive one cycle's inputs on the falling edge and queue what the DUT must show before the next rise.
   task automatic drive(input stim_t s, input exp_t ex);
      @(negedge clk);
      apply(s);
      sb.push_back(ex);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      apply(S_IDLE);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      stim_t s;
      s = S_LU;
      s.mds = 1'b1;
      drive(s, mk(C_OFF, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL reset_hold: got %h want %h", obs1, e); else n_pass++;
      s.redir = 1'b1;
      drive(s, mk(C_OFF, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL reset_redir: got %h want %h", obs1, e); else n_pass++;
      @(negedge clk);
      apply(S_IDLE);
      rst_n = 1'b1;
      drive(S_IDLE, mk(C_NORM, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL reset_release: got %h want %h", obs1, e); else n_pass++;
   endtask

   task automatic test_load_use();
      stim_t s;
      do_reset();
      drive(S_LU, mk(C_STALL, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL lu_rs_stall: got %h want %h", obs1, e); else n_pass++;
      drive(S_IDLE, mk(C_NORM, 1'b0, 1, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL lu_release: got %h want %h", obs1, e); else n_pass++;
      s = S_IDLE; s.mr = 1'b1; s.rd = 5'd9; s.rt = 5'd9; s.urt = 1'b1;
      drive(s, mk(C_STALL, 1'b0, 1, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL lu_rt_stall: got %h want %h", obs1, e); else n_pass++;
      drive(S_IDLE, mk(C_NORM, 1'b0, 2, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL lu_rt_release: got %h want %h", obs1, e); else n_pass++;
   endtask

   task automatic test_zero_unused();
      stim_t s;
      do_reset();
      s = S_IDLE; s.mr = 1'b1; s.urs = 1'b1;
      drive(s, mk(C_NORM, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL zero_reg: got %h want %h", obs1, e); else n_pass++;
      s = S_IDLE; s.mr = 1'b1; s.rd = 5'd9; s.rt = 5'd9; s.urs = 1'b1; s.rs = 5'd3;
      drive(s, mk(C_NORM, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL unused_rt: got %h want %h", obs1, e); else n_pass++;
      drive(S_IDLE, mk(C_NORM, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL unused_after: got %h want %h", obs1, e); else n_pass++;
   endtask

   task automatic test_md();
      do_reset();
      drive(S_MDS, mk(C_NORM, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL md_issue: got %h want %h", obs1, e); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         drive(S_MDU, mk(C_STALL, 1'b1, i, 0));
         e = sb.pop_front(); n_chk++;
         if (obs1 !== e) $display("FAIL md_stall_%0d: got %h want %h", i, obs1, e); else n_pass++;
      end
      drive(S_MDU, mk(C_NORM, 1'b0, 5, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL md_release: got %h want %h", obs1, e); else n_pass++;
      drive(S_MDS, mk(C_NORM, 1'b0, 5, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL md_issue2: got %h want %h", obs1, e); else n_pass++;
      drive(S_MDS, mk(C_STALL, 1'b1, 5, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL md_start_busy: got %h want %h", obs1, e); else n_pass++;
      drive(S_IDLE, mk(C_NORM, 1'b1, 6, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL md_start_after: got %h want %h", obs1, e); else n_pass++;
   endtask

   task automatic test_redirect();
      stim_t s;
      do_reset();
      s = S_LU; s.redir = 1'b1;
      drive(s, mk(C_REDIR, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_over_lu: got %h want %h", obs1, e); else n_pass++;
      drive(S_IDLE, mk(C_NORM, 1'b0, 0, 1));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_counts: got %h want %h", obs1, e); else n_pass++;
   endtask

   task automatic test_redirect_md();
      stim_t s;
      do_reset();
      s = S_MDS; s.redir = 1'b1;
      drive(s, mk(C_REDIR, 1'b0, 0, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_mds: got %h want %h", obs1, e); else n_pass++;
      drive(S_IDLE, mk(C_NORM, 1'b0, 0, 1));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_mds_noload: got %h want %h", obs1, e); else n_pass++;
      drive(S_MDS, mk(C_NORM, 1'b0, 0, 1));
      void'(sb.pop_front());
      drive(S_IDLE, mk(C_NORM, 1'b1, 0, 1));
      void'(sb.pop_front());
      drive(S_IDLE, mk(C_NORM, 1'b1, 0, 1));
      void'(sb.pop_front());
      drive(S_RED, mk(C_REDIR, 1'b1, 0, 1));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_cnt3: got %h want %h", obs1, e); else n_pass++;
      drive(S_MDU, mk(C_STALL, 1'b1, 0, 2));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_cnt2: got %h want %h", obs1, e); else n_pass++;
      drive(S_MDU, mk(C_STALL, 1'b1, 1, 2));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_cnt1: got %h want %h", obs1, e); else n_pass++;
      drive(S_MDU, mk(C_NORM, 1'b0, 2, 2));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL redir_cnt0: got %h want %h", obs1, e); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(S_RED, mk(C_REDIR, 1'b0, 0, 0));
      void'(sb.pop_front());
      for (int i = 0; i < 7; i++) begin
         drive(S_LU, mk(C_STALL, 1'b0, i, 1));
         void'(sb.pop_front());
      end
      drive(S_MDS, mk(C_NORM, 1'b0, 7, 1));
      void'(sb.pop_front());
      drive(S_IDLE, mk(C_NORM, 1'b1, 7, 1));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL arst_pre: got %h want %h", obs1, e); else n_pass++;
      @(posedge clk);
      #2;
      apply(S_LU);
      rst_n = 1'b0;
      sb.push_back(mk(C_OFF, 1'b0, 0, 0));
      #1;
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL arst_clear: got %h want %h", obs1, e); else n_pass++;
      n_chk++;
      if ({if2.md_busy, if2.stall_cnt, if2.flush_cnt} !== 9'd0)
         $display("FAIL arst_clear_sat: got %h want 0", {if2.md_busy, if2.stall_cnt, if2.flush_cnt});
      else n_pass++;
      @(negedge clk);
      apply(S_IDLE);
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(S_LU, mk(C_STALL, 1'b0, i, 0));
         e = sb.pop_front();
         if (i == 19) begin
            n_chk++;
            if (obs1 !== e) $display("FAIL sat_wide_19: got %h want %h", obs1, e); else n_pass++;
         end
      end
      drive(S_IDLE, mk(C_NORM, 1'b0, 20, 0));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) $display("FAIL sat_wide_end: got %h want %h", obs1, e); else n_pass++;
      n_chk++;
      if (if2.stall_cnt !== 4'd15) $display("FAIL sat_narrow: got %0d want 15", if2.stall_cnt);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      apply(S_IDLE);
      test_reset();
      test_load_use();
      test_zero_unused();
      test_md();
      test_redirect();
      test_redirect_md();
      test_async_reset();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generates the PC enable plus per-stage pipeline-register enables and flushes from three sources:
  - control redirect resolved in MEM;
  - load-use hazard between EX and ID;
  - structural/data hazard on the multi-cycle multiply/divide unit.
- Tracks MD unit occupancy with an internal down-counter and keeps saturating stall/flush performance counters.
- Sits beside the forwarding unit. Its outputs drive the PC and the four mid-stage registers directly.

Parameters:
- MD_CYCLES, 5, EX-stage occupancy of the MD unit after issue, in cycles (1..31).
- CNT_W, 16, width of each performance counter.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Ex_MemRead  in  1  instruction in EX is a load.
- Ex_rd  in  5  destination register of instruction in EX.
- Id_rs  in  5  rs field of instruction in ID.
- Id_rt  in  5  rt field of instruction in ID.
- Id_UseRs  in  1  ID instruction reads rs.
- Id_UseRt  in  1  ID instruction reads rt.
- Id_MdStart  in  1  ID instruction is mult/div (issues to MD unit on advance).
- Id_MdUse  in  1  ID instruction reads HI/LO (mfhi/mflo).
- MeM_Redirect  in  1  branch taken / jump / jr resolved in MEM this cycle.
- Pcen  out  1  PC load enable.
- IfIdEn  out  1  IF/ID register write enable.
- IdExEn  out  1  ID/EX register write enable.
- ExMemEn  out  1  EX/MEM register write enable.
- MemWbEn  out  1  MEM/WB register write enable.
- IfIdFlush  out  1  load bubble into IF/ID.
- IdExFlush  out  1  load bubble into ID/EX.
- ExMemFlush  out  1  load bubble into EX/MEM.
- MdBusy  out  1  MD counter nonzero.
- StallCnt  out  CNT_W  cycles with a stall applied.
- FlushCnt  out  CNT_W  redirect events.

Behaviour:
- Reset:
  - While Rst=0: md_cnt=0, StallCnt=0, FlushCnt=0.
  - All En outputs = 0, all Flush outputs = 0, MdBusy=0.
  - Release is effective on the first rising edge with Rst=1.
- Hazard terms (combinational, same cycle):
  - lu = Ex_MemRead & (Ex_rd!=0) & ((Id_UseRs & Id_rs==Ex_rd) | (Id_UseRt & Id_rt==Ex_rd)).
  - md = (md_cnt!=0) & (Id_MdUse | Id_MdStart).
  - stall = (lu | md) & ~MeM_Redirect.
- Priority: MeM_Redirect > md > lu.
- Redirect cycle:
  - Pcen=1, all En=1.
  - IfIdFlush=IdExFlush=ExMemFlush=1.
  - MemWbEn=1; MEM-stage instruction completes.
  - Any pending stall is discarded.
- Stall cycle:
  - Pcen=0, IfIdEn=0.
  - IdExEn=1 with IdExFlush=1 (bubble inserted).
  - ExMemEn=MemWbEn=1.
  - IfIdFlush=ExMemFlush=0.
- Normal cycle: all En=1, all Flush=0.
- MD counter:
  - If Id_MdStart & ~stall & ~MeM_Redirect: md_cnt <= MD_CYCLES.
  - Else if md_cnt!=0: md_cnt <= md_cnt-1.
  - Redirect does not cancel a running count; the op has already issued.
  - A flushed MdStart in ID does not load the counter.
- Load-use stall is exactly 1 cycle: next cycle the load is in MEM and forwarding covers it.
- md stall lasts until md_cnt reaches 0. It may overlap lu; only one stall is counted per cycle.
- Performance counters:
  - StallCnt += 1 on every stall cycle.
  - FlushCnt += 1 on every MeM_Redirect cycle.
  - Both saturate at 2^CNT_W-1, no wrap.
- Outputs other than MdBusy/StallCnt/FlushCnt are combinational from inputs and md_cnt.
- MdBusy, StallCnt and FlushCnt reflect registered state.
- Reset mid-stall: counters and md_cnt clear immediately (async); the held instruction is discarded by the pipeline registers' own reset.

Test Plan:
- Load-use: Ex_MemRead=1, Ex_rd=8, Id_rs=8, Id_UseRs=1 for one cycle.
  - Required: Pcen=0, IfIdEn=0, IdExFlush=1 that cycle; StallCnt 0->1.
  - Next cycle with Ex_MemRead=0: all En=1.
- $0 and unused fields:
  - Ex_rd=0 with matching Id_rs: no stall.
  - Ex_rd=9, Id_rt=9, Id_UseRt=0: no stall.
- MD sequence (MD_CYCLES=5): Id_MdStart pulse, then Id_MdUse=1 held.
  - Required: MdBusy=1 for 5 cycles; stall for the 5 cycles md_cnt=5..1.
  - Then released; StallCnt=5.
  - Second Id_MdStart while busy also stalls.
- Redirect overrides stall: MeM_Redirect=1 concurrent with an lu condition.
  - Required: Pcen=1; IfIdFlush=IdExFlush=ExMemFlush=1; StallCnt unchanged; FlushCnt +1.
- Redirect with MdStart in ID: md_cnt not loaded, MdBusy stays 0.
  - A redirect while md_cnt=3 lets the count continue: 2, 1, 0.
- Async reset with md_cnt=4, StallCnt=7:
  - Drop Rst between edges: MdBusy, StallCnt, FlushCnt read 0 immediately; all En=0.
- Saturation (CNT_W=4): 20 consecutive stall cycles -> StallCnt holds 15.
